// File: rtl/stream_arb_pkg.sv
// Shared types and the round-robin search helper for the stream arbiter.
// Holds the FSM state enum, pick result struct and rr_next().
package stream_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MAX_PORT = 8;
    localparam int MAX_IDW  = 3;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDW-1:0]   idx;
    } pick_t;

    // First set bit of req in the order start, start+1, ... modulo n.
    function automatic pick_t rr_next(
        input logic [MAX_PORT-1:0] req,
        input logic [MAX_IDW-1:0]  start,
        input int                  n
    );
        pick_t r;
        int    k;
        r = '0;
        for (int i = 0; i < MAX_PORT; i++) begin
            if (!r.found && i < n) begin
                k = (int'(start) + i) % n;
                if (req[k[MAX_IDW-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = k[MAX_IDW-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_rr_pick.sv
// Combinational round-robin picker: first requester from i_start upward.
// Ports: i_req (request vector), i_start (first index searched),
//        o_found (any requester), o_idx (chosen index).
module stream_rr_pick
    import stream_arb_pkg::*;
#(
    parameter int N_PORT = 4,
    parameter int IDW    = 2
) (
    input  logic [N_PORT-1:0] i_req,
    input  logic [IDW-1:0]    i_start,
    output logic              o_found,
    output logic [IDW-1:0]    o_idx
);

    logic [MAX_PORT-1:0] w_req;
    logic [MAX_IDW-1:0]  w_start;
    pick_t               w_pick;

    always_comb begin
        w_req                 = '0;
        w_req[N_PORT-1:0]     = i_req;
        w_start               = '0;
        w_start[IDW-1:0]      = i_start;
        w_pick                = rr_next(w_req, w_start, N_PORT);
    end

    assign o_found = w_pick.found;
    assign o_idx   = w_pick.idx[IDW-1:0];

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin N-to-1 stream arbiter with per-grant burst limit.
// Ports: clk/rst, ivalid/iready/idata (N inputs), otvalid/otready/otdata/otid
//        (merged output + granted port index), busy (grant active).
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter  int N_PORT = 4,
    parameter  int DEXP   = 0,
    parameter  int BURST  = 16,
    localparam int DW     = 8 << DEXP,
    localparam int IDW    = (N_PORT > 2) ? $clog2(N_PORT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_PORT-1:0]    ivalid,
    output logic [N_PORT-1:0]    iready,
    input  logic [N_PORT*DW-1:0] idata,
    output logic                 otvalid,
    input  logic                 otready,
    output logic [DW-1:0]        otdata,
    output logic [IDW-1:0]       otid,
    output logic                 busy
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(N_PORT - 1);
    localparam logic [8:0]     CNT_END  = 9'(BURST - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_gnt;
    logic [IDW-1:0] w_gnt_nxt;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] w_last_nxt;
    logic [8:0]     r_cnt;
    logic [8:0]     w_cnt_nxt;

    logic           w_sel_valid;
    logic [DW-1:0]  w_sel_data;
    logic [IDW-1:0] w_base;
    logic [IDW-1:0] w_start;
    logic           w_pick_found;
    logic [IDW-1:0] w_pick_idx;
    logic           w_beat;
    logic           w_release;

    // Granted-port mux; gnt never exceeds N_PORT-1.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int k = 0; k < N_PORT; k++) begin
            if (IDW'(k) == r_gnt) begin
                w_sel_valid = ivalid[k];
                w_sel_data  = idata[k*DW +: DW];
            end
        end
    end

    // Search starts just past the last owner, so that owner ends up lowest.
    assign w_base  = (r_state == GRANT) ? r_gnt : r_last;
    assign w_start = (w_base == LAST_IDX) ? '0 : w_base + IDW'(1);

    stream_rr_pick #(
        .N_PORT (N_PORT),
        .IDW    (IDW)
    ) u_pick (
        .i_req   (ivalid),
        .i_start (w_start),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    assign w_beat    = (r_state == GRANT) && w_sel_valid && otready;
    assign w_release = (r_state == GRANT) &&
                       (!w_sel_valid || (w_beat && r_cnt == CNT_END));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_last_nxt = r_gnt;
                    w_cnt_nxt  = '0;
                    if (w_pick_found) begin
                        w_gnt_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_beat) begin
                    w_cnt_nxt = r_cnt + 9'd1;
                end
            end
        endcase
    end

    // Outputs are gated by rst so nothing is accepted in a reset cycle.
    always_comb begin
        iready  = '0;
        otvalid = 1'b0;
        otdata  = '0;
        otid    = r_last;
        busy    = 1'b0;
        if (rst) begin
            otid = LAST_IDX;
        end else if (r_state == GRANT) begin
            otvalid = w_sel_valid;
            otdata  = w_sel_data;
            otid    = r_gnt;
            busy    = 1'b1;
            for (int k = 0; k < N_PORT; k++) begin
                if (IDW'(k) == r_gnt) begin
                    iready[k] = otready;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= LAST_IDX;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter N_PORT, default 4, number of input streams (legal 2..8).
REQ-002 SHALL have parameter DEXP, default 0, stream width 8<<DEXP bits (0=1Byte, 1=2Byte, 2=4Byte, ...).
REQ-003 SHALL have parameter BURST, default 16, maximum beats per grant (legal 1..256).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 ivalid  input  N_PORT  per-port valid.
REQ-008 iready  output  N_PORT  per-port ready.
REQ-009 idata  input  N_PORT*(8<<DEXP)  flattened data, port k at bits [k*(8<<DEXP) +: 8<<DEXP].
REQ-010 otvalid  output  1  merged stream valid.
REQ-011 otready  input  1  merged stream ready.
REQ-012 otdata  output  8<<DEXP  merged stream data.
REQ-013 otid  output  IDW=max(1,clog2(N_PORT))  index of the granted port.
REQ-014 busy  output  1  high while in state GRANT.

Function
REQ-015 SHALL implement states IDLE and GRANT, plus registers gnt (IDW bits), last (IDW bits) and cnt (9 bits).
REQ-016 In IDLE, otvalid=0, iready=0, otdata=0 and otid=last.
REQ-017 In IDLE, if any ivalid is high, the block SHALL pick the first port with ivalid high, searching last+1, last+2, ... modulo N_PORT, with last itself searched at the end.
REQ-018 On such a pick the block SHALL load gnt, clear cnt and enter GRANT on the next edge; latency from first ivalid to otvalid is 1 cycle.
REQ-019 In GRANT, otvalid=ivalid[gnt], otdata=idata[gnt], otid=gnt, iready[gnt]=otready, and every other iready is 0; the path is combinational with no buffering.
REQ-020 A beat is a cycle with ivalid[gnt] and otready both high; each beat SHALL increment cnt.
REQ-021 The grant SHALL be released on the beat where cnt==BURST-1, or in any cycle where ivalid[gnt]==0.
REQ-022 On release, last SHALL be loaded with gnt.
REQ-023 On release, the round-robin pick SHALL be evaluated in the same cycle over the current ivalid, starting from gnt+1.
REQ-024 Ivalid[gnt] SHALL be included in the release pick only as the lowest priority, so a sole requester is re-granted.
REQ-025 If the release pick finds a port, the block SHALL go GRANT to GRANT with no bubble and cnt cleared; otherwise it SHALL enter IDLE.
REQ-026 Release and beat in the same cycle: the beat SHALL complete before ownership moves, so no data is lost or duplicated.
REQ-027 Ivalid of non-granted ports SHALL be ignored, and their data held by the source, until they are granted.
REQ-028 With BURST=1, every beat SHALL release the grant.
REQ-029 Ports beyond N_PORT-1 SHALL never be granted, and gnt arithmetic SHALL wrap modulo N_PORT, not modulo 2^IDW.

Reset
REQ-030 While rst=1: state=IDLE, gnt=0, last=N_PORT-1 (first pick starts at port 0), cnt=0.
REQ-031 While rst=1: otvalid=0, iready=0, otdata=0, otid=N_PORT-1, busy=0.
REQ-032 Reset asserted mid-burst SHALL abort the grant on the next edge, with no beat accepted in the reset cycle (iready=0).

Structure
REQ-033 Package stream_arb_pkg SHALL hold the state enum (IDLE, GRANT) and function rr_next(req, start, n), which returns a found flag and an index.
REQ-034 Combinational sub-module stream_rr_pick (req vector, start index -> found, index) SHALL be used for both the IDLE pick and the release pick.
REQ-035 No other sub-modules SHALL be instantiated.

Verification
REQ-036 Ports 0..3 continuously valid, BURST=4, otready=1 -> after reset, otid sequence 0x4, 1x4, 2x4, 3x4, 0..., with no idle cycle between grants.
REQ-037 Only port 2 valid, BURST=4, 10 beats -> 3 consecutive grants to port 2, bursts of 4, 4, 2, then IDLE when valid drops.
REQ-038 Port 1 granted, otready low for 5 cycles mid-burst -> otdata stable, cnt frozen, no release, iready[1]=0 for those 5 cycles.
REQ-039 Port 0 drops ivalid after 2 beats while port 3 is valid -> release in that cycle and otid=3 in the next cycle, with cnt restarted at 0.
REQ-040 rst pulsed on the 3rd beat of port 1's burst -> next cycle busy=0, all iready=0; first post-reset grant is port 0 if it is valid.
REQ-041 BURST=1, ports 0 and 1 valid, random otready -> strict alternation 0,1,0,1, and every idata word appears exactly once on otdata.
